// File: rtl/button_debounce_ctrl.sv
// Debounces WIDTH raw pin inputs: 2-FF synchronizer, one shared sample-tick
// scheduler, per-bit saturating qualify FSMs, clean levels and rising-edge pulses.

module synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

module button_debounce_ctrl #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise_pulse
);

  localparam int CW = $clog2(SAMPLE_CNT_MAX);
  localparam int PW = $clog2(PULSE_CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_STABLE   = 2'd2
  } state_e;

  logic [WIDTH-1:0] s;
  logic [CW-1:0]    smp_cnt_q, smp_cnt_d;
  logic             tick;
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [PW-1:0]    cnt_q [WIDTH];
  logic [PW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] debounced_q, debounced_d;
  logic [WIDTH-1:0] rise_pulse_q, rise_pulse_d;

  synchronizer #(.WIDTH(WIDTH)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (async_in),
    .q    (s)
  );

  // Free-running scheduler; input activity never restarts it.
  always_comb begin
    tick      = (smp_cnt_q == CW'(SAMPLE_CNT_MAX - 1));
    smp_cnt_d = tick ? '0 : smp_cnt_q + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // A low synchronized sample clears the bit immediately, tick or not.
      if (!s[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else if (tick) begin
        case (state_q[i])
          ST_IDLE: begin
            cnt_d[i]   = PW'(1);
            state_d[i] = (PULSE_CNT_MAX == 1) ? ST_STABLE : ST_COUNTING;
          end
          ST_COUNTING: begin
            cnt_d[i] = cnt_q[i] + 1'b1;
            if (cnt_q[i] == PW'(PULSE_CNT_MAX - 1)) state_d[i] = ST_STABLE;
          end
          ST_STABLE: begin
            state_d[i] = ST_STABLE;
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      debounced_d[i] = (state_d[i] == ST_STABLE);
    end
    rise_pulse_d = debounced_d & ~debounced_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_q    <= '0;
      debounced_q  <= '0;
      rise_pulse_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      smp_cnt_q    <= smp_cnt_d;
      debounced_q  <= debounced_d;
      rise_pulse_q <= rise_pulse_d;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign debounced  = debounced_q;
  assign rise_pulse = rise_pulse_q;

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Directed bench for button_debounce_ctrl with a 4-cycle sample tick,
// 3-sample qualification and two input bits.

module tb_button_debounce_ctrl;

  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] async_in;
  logic [W-1:0] debounced;
  logic [W-1:0] rise_pulse;

  int checks = 0;
  int errors = 0;

  button_debounce_ctrl #(
    .WIDTH         (W),
    .SAMPLE_CNT_MAX(4),
    .PULSE_CNT_MAX (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (async_in),
    .debounced (debounced),
    .rise_pulse(rise_pulse)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    async_in = v;
  endtask

  // Waits for all mask bits to go high, checks latency window, the one-cycle
  // pulse coinciding with the rise, and that the pulse is gone one cycle later.
  task automatic measure(input string tag, input logic [W-1:0] mask,
                         input int lo, input int hi);
    int got;
    logic [W-1:0] pulse_at_rise;
    got = 0;
    pulse_at_rise = '0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if ((debounced & mask) == mask) begin
        got = k;
        pulse_at_rise = rise_pulse & mask;
        break;
      end
    end
    check({tag, "_latency_in_window"}, 32'((got >= lo) && (got <= hi)), 32'd1);
    check({tag, "_pulse_at_rise"}, 32'(pulse_at_rise), 32'(mask));
    @(posedge clk);
    #1;
    check({tag, "_pulse_gone"}, 32'(rise_pulse & mask), 32'd0);
    check({tag, "_level_held"}, 32'(debounced & mask), 32'(mask));
  endtask

  initial begin
    int bad;
    int p0, p1, r0, r1, drops;

    // 1: reset holds everything at zero even with inputs high
    rst_n    = 1'b0;
    async_in = 2'b11;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (debounced !== 2'b00 || rise_pulse !== 2'b00) bad++;
    end
    check("reset_outputs_zero", 32'(bad), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    measure("reset_release", 2'b11, 11, 14);
    drive(2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("both_release", 32'(debounced), 32'd0);
    repeat (4) @(posedge clk);

    // 2: clean press on bit 0
    drive(2'b01);
    measure("clean_press", 2'b01, 11, 14);
    check("clean_press_bit1_low", 32'(debounced[1]), 32'd0);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (rise_pulse !== 2'b00 || debounced !== 2'b01) bad++;
    end
    check("clean_press_hold", 32'(bad), 32'd0);

    // 4: release drops in 3 cycles without pulse, then re-press pulses again
    drive(2'b00);
    bad = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (rise_pulse !== 2'b00) bad++;
      if (k == 2) check("release_still_high_c2", 32'(debounced[0]), 32'd1);
    end
    check("release_low_c3", 32'(debounced[0]), 32'd0);
    check("release_no_pulse", 32'(bad), 32'd0);
    repeat (5) @(posedge clk);
    drive(2'b01);
    measure("repress", 2'b01, 11, 14);
    drive(2'b00);
    repeat (6) @(posedge clk);

    // 3: glitches shorter than a qualifying run never assert
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      async_in = ((k / 3) % 2 == 0) ? 2'b01 : 2'b00;
      @(posedge clk);
      #1;
      if (debounced !== 2'b00 || rise_pulse !== 2'b00) bad++;
    end
    drive(2'b00);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (debounced !== 2'b00 || rise_pulse !== 2'b00) bad++;
    end
    check("glitch_reject", 32'(bad), 32'd0);

    // 5: reset mid-count restarts qualification from release
    drive(2'b10);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_debounced", 32'(debounced), 32'd0);
    check("midreset_pulse", 32'(rise_pulse), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    measure("midreset_release", 2'b10, 11, 14);
    drive(2'b00);
    repeat (6) @(posedge clk);

    // 6: independent bits, saturation, no extra pulses
    p0 = 0; p1 = 0; r0 = 0; r1 = 0; drops = 0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk);
      if (k == 1) async_in[0] = 1'b1;
      if (k == 6) async_in[1] = 1'b1;
      @(posedge clk);
      #1;
      if (rise_pulse[0]) p0++;
      if (rise_pulse[1]) p1++;
      if (debounced[0] && r0 == 0) r0 = k;
      if (debounced[1] && r1 == 0) r1 = k;
      if ((r0 != 0 && !debounced[0]) || (r1 != 0 && !debounced[1])) drops++;
    end
    check("indep_pulses_bit0", 32'(p0), 32'd1);
    check("indep_pulses_bit1", 32'(p1), 32'd1);
    check("indep_rise_bit0_window", 32'((r0 >= 11) && (r0 <= 14)), 32'd1);
    check("indep_rise_bit1_window", 32'((r1 >= 16) && (r1 <= 19)), 32'd1);
    check("indep_saturate_no_drop", 32'(drops), 32'd0);
    check("indep_final_level", 32'(debounced), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
